// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Read-side burst consumer for a FIFO. A start command pops
//                exactly len_i words through the FIFO read port. The words
//                are re-streamed on a valid/ready master interface with a
//                last marker. A done pulse follows the final handshake. A
//                2-entry skid buffer absorbs the FIFO's one-cycle registered
//                read latency.
//  Ports       : clk_i, rst_n_i          - clock, async active-low reset
//                start_i, len_i          - burst command (len sampled on start)
//                fifo_empty_i            - FIFO empty flag
//                fifo_rd_data_i          - FIFO data, one cycle after rd_en
//                fifo_rd_en_o            - FIFO pop request
//                m_valid_o/m_ready_i     - output handshake
//                m_data_o, m_last_o      - output word and end-of-burst mark
//                busy_o, done_o, error_o - status
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rd_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_rd_left;
  logic [LEN_WIDTH-1:0]  r_out_left;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [WIDTH-1:0]      r_buf [0:1];
  logic                  r_wptr;
  logic                  r_rptr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic                  w_xfer;
  logic [1:0]            w_outstanding;
  logic                  w_rd_en;

  // Words already committed to the buffer: stored entries plus the one
  // still on its way from the FIFO. Popping only below 2 means every popped
  // word always has a buffer slot, whatever the downstream does.
  assign w_outstanding = r_occ + {1'b0, r_inflight};

  assign w_rd_en = (r_state == S_READ) && (r_rd_left != '0) &&
                   !fifo_empty_i && (w_outstanding < 2'd2);

  assign m_valid_o    = (r_occ != 2'd0);
  assign m_data_o     = r_buf[r_rptr];
  assign m_last_o     = m_valid_o && (r_out_left == c_LEN_ONE);
  assign w_xfer       = m_valid_o && m_ready_i;
  assign fifo_rd_en_o = w_rd_en;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_rd_left  <= '0;
      r_out_left <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_inflight <= w_rd_en;

      // The FIFO presents popped data one cycle after the pop, so the
      // in-flight flag doubles as the buffer write strobe.
      if (r_inflight) begin
        r_buf[r_wptr] <= fifo_rd_data_i;
        r_wptr        <= ~r_wptr;
      end

      if (w_xfer) begin
        r_rptr <= ~r_rptr;
        if (r_out_left != '0) begin
          r_out_left <= r_out_left - c_LEN_ONE;
        end
      end

      case ({r_inflight, w_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              r_rd_left  <= len_i;
              r_out_left <= len_i;
              r_busy     <= 1'b1;
              r_state    <= S_READ;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (start_i) begin
            r_error <= 1'b1;
          end
          if (w_rd_en) begin
            r_rd_left <= r_rd_left - c_LEN_ONE;
            if (r_rd_left == c_LEN_ONE) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (start_i) begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // The last word cannot leave before it was popped, so this only fires
      // once the pops are complete. It overrides the state case above.
      if ((r_state != S_IDLE) && w_xfer && (r_out_left == c_LEN_ONE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Directed self-checking bench for fifo_burst_reader. Contains
//                a registered-read FIFO model and a negedge monitor that
//                records transfers and status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] len = 6'd0;
  logic       fifo_empty;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_burst_reader #(.WIDTH(8), .LEN_WIDTH(6)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .len_i          (len),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_q),
    .fifo_rd_en_o   (fifo_rd_en),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .m_last_o       (m_last),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  // ---------------- FIFO model (registered read) ----------------
  logic [7:0] mem [0:511];
  logic [8:0] wr_ptr = 9'd0;
  logic [8:0] rd_ptr = 9'd0;
  logic       flush  = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 9'd1;
    end
  end

  // ---------------- monitor ----------------
  logic [7:0] xd [$];
  logic       xl [$];
  int pops = 0, dones = 0, errs = 0, underflow = 0, unstable = 0, credit_viol = 0;
  int outst = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst  <= 0;
      prev_v <= 1'b0;
    end else begin
      if (fifo_rd_en) pops <= pops + 1;
      if (fifo_rd_en && fifo_empty) underflow <= underflow + 1;
      if (fifo_rd_en && outst >= 2) credit_viol <= credit_viol + 1;
      if (prev_v && !prev_r && (!m_valid || m_data != prev_d || m_last != prev_l))
        unstable <= unstable + 1;
      if (m_valid && m_ready) begin
        xd.push_back(m_data);
        xl.push_back(m_last);
      end
      if (done)  dones <= dones + 1;
      if (error) errs  <= errs + 1;
      outst  <= outst + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      prev_v <= m_valid;
      prev_r <= m_ready;
      prev_d <= m_data;
      prev_l <= m_last;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 9'd1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_checks++;
    if ({fifo_rd_en, m_valid, m_last, busy, done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {fifo_rd_en, m_valid, m_last, busy, done, error});
    end
    n_checks++;
    if (m_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00", m_data);
    end
    rst_n = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({m_valid, busy, fifo_rd_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 000", {m_valid, busy, fifo_rd_en});
    end
  endtask

  task automatic test_basic;
    int  base, p0, d0, cyc;
    bit  ok;
    logic [7:0] exp_d;
    do_flush;
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    m_ready = 1'b1;
    base = xd.size(); p0 = pops; d0 = dones;
    len = 6'd4; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!m_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL basic_first_valid_latency: got %0d required 3", cyc);
    end
    wait_done(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: got no done required done");
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_in_done_cycle: got %b required 0", busy);
    end
    tick;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_single_cycle: got %b required 0", done);
    end
    n_checks++;
    if (xd.size() - base !== 4) begin
      n_fail++;
      $display("FAIL basic_word_count: got %0d required 4", xd.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h11 + 8'(i);
      n_checks++;
      if (xd[base+i] !== exp_d || xl[base+i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h/last %b required %h/last %b",
                 i, xd[base+i], xl[base+i], exp_d, (i == 3));
      end
    end
    n_checks++;
    if (pops - p0 !== 4 || dones - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_pops_dones: got %0d/%0d required 4/1", pops - p0, dones - d0);
    end
  endtask

  task automatic test_backpressure;
    int  base, p0, u0, c0;
    bit  seen;
    logic [7:0] exp_d;
    do_flush;
    for (int i = 0; i < 6; i++) push(8'h21 + 8'(i));
    base = xd.size(); p0 = pops; u0 = unstable; c0 = credit_viol;
    m_ready = 1'b1;
    len = 6'd6; start = 1'b1;
    tick;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i < 10)      m_ready = (i % 2 == 0);
      else if (i < 15) m_ready = 1'b0;
      else             m_ready = 1'b1;
      tick;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    tick;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_done_timeout: got no done required done");
    end
    n_checks++;
    if (xd.size() - base !== 6) begin
      n_fail++;
      $display("FAIL bp_word_count: got %0d required 6", xd.size() - base);
    end
    for (int i = 0; i < 6; i++) begin
      exp_d = 8'h21 + 8'(i);
      n_checks++;
      if (xd[base+i] !== exp_d || xl[base+i] !== (i == 5)) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h/last %b required %h/last %b",
                 i, xd[base+i], xl[base+i], exp_d, (i == 5));
      end
    end
    n_checks++;
    if (unstable - u0 !== 0) begin
      n_fail++;
      $display("FAIL bp_stall_stability: got %0d changes required 0", unstable - u0);
    end
    n_checks++;
    if (credit_viol - c0 !== 0) begin
      n_fail++;
      $display("FAIL bp_credit: got %0d pops with 2 outstanding required 0", credit_viol - c0);
    end
    n_checks++;
    if (pops - p0 !== 6) begin
      n_fail++;
      $display("FAIL bp_pops: got %0d required 6", pops - p0);
    end
  endtask

  task automatic test_empty_stall;
    int  base, u0;
    bit  ok;
    logic [7:0] exp_d;
    do_flush;
    push(8'h31);
    base = xd.size(); u0 = underflow;
    m_ready = 1'b1;
    len = 6'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    n_checks++;
    if (xd.size() - base !== 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_partial: got %0d words busy %b required 1 words busy 1",
               xd.size() - base, busy);
    end
    push(8'h32);
    push(8'h33);
    wait_done(40, ok);
    tick;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_done_timeout: got no done required done");
    end
    n_checks++;
    if (xd.size() - base !== 3) begin
      n_fail++;
      $display("FAIL stall_word_count: got %0d required 3", xd.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      exp_d = 8'h31 + 8'(i);
      n_checks++;
      if (xd[base+i] !== exp_d || xl[base+i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL stall_word%0d: got %h/last %b required %h/last %b",
                 i, xd[base+i], xl[base+i], exp_d, (i == 2));
      end
    end
    n_checks++;
    if (underflow - u0 !== 0) begin
      n_fail++;
      $display("FAIL stall_underflow: got %0d pops while empty required 0", underflow - u0);
    end
  endtask

  task automatic test_illegal;
    int  base, p0;
    bit  ok;
    logic [7:0] exp_d;
    do_flush;
    m_ready = 1'b1;
    len = 6'd0; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_len0: got error %b busy %b required 1 0", error, busy);
    end
    tick;
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_len0_pulse: got error %b busy %b required 0 0", error, busy);
    end
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
    base = xd.size(); p0 = pops;
    len = 6'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    len = 6'd3; start = 1'b1;
    tick;
    start = 1'b0;
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_midburst: got error %b busy %b required 1 1", error, busy);
    end
    wait_done(50, ok);
    tick;
    n_checks++;
    if (!ok || xd.size() - base !== 5 || pops - p0 !== 5) begin
      n_fail++;
      $display("FAIL illegal_burst_len: got done %b words %0d pops %0d required 1 5 5",
               ok, xd.size() - base, pops - p0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'h51 + 8'(i);
      n_checks++;
      if (xd[base+i] !== exp_d || xl[base+i] !== (i == 4)) begin
        n_fail++;
        $display("FAIL illegal_word%0d: got %h/last %b required %h/last %b",
                 i, xd[base+i], xl[base+i], exp_d, (i == 4));
      end
    end
  endtask

  task automatic test_reset_midburst;
    int  base;
    bit  ok;
    logic [7:0] e0, e1;
    do_flush;
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    m_ready = 1'b1;
    base = xd.size();
    len = 6'd8; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (xd.size() - base >= 2) break;
      tick;
    end
    n_checks++;
    if (xd.size() - base < 2) begin
      n_fail++;
      $display("FAIL rstmid_reach2: got %0d words required 2", xd.size() - base);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, fifo_rd_en, busy, m_last, m_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_async_outputs: got %h required 000",
               {m_valid, fifo_rd_en, busy, m_last, m_data});
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    e0 = mem[rd_ptr];
    e1 = mem[rd_ptr + 9'd1];
    base = xd.size();
    len = 6'd2; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(30, ok);
    tick;
    n_checks++;
    if (!ok || xd.size() - base !== 2) begin
      n_fail++;
      $display("FAIL rstmid_restart: got done %b words %0d required 1 2", ok, xd.size() - base);
    end
    n_checks++;
    if (xd[base] !== e0 || xd[base+1] !== e1 || xl[base] !== 1'b0 || xl[base+1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_words: got %h %h last %b%b required %h %h last 01",
               xd[base], xd[base+1], xl[base], xl[base+1], e0, e1);
    end
  endtask

  task automatic test_back_to_back;
    int  base, d0, e0;
    bit  ok1, ok2;
    logic [7:0] exp_d;
    do_flush;
    for (int i = 0; i < 64; i++) push(8'h80 + 8'(i));
    m_ready = 1'b1;
    base = xd.size(); d0 = dones; e0 = errs;
    len = 6'd63; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(400, ok1);
    len = 6'd1; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(50, ok2);
    tick;
    n_checks++;
    if (!ok1 || !ok2) begin
      n_fail++;
      $display("FAIL b2b_done_timeout: got %b%b required 11", ok1, ok2);
    end
    n_checks++;
    if (xd.size() - base !== 64) begin
      n_fail++;
      $display("FAIL b2b_word_count: got %0d required 64", xd.size() - base);
    end
    for (int i = 0; i < 64; i++) begin
      exp_d = 8'h80 + 8'(i);
      n_checks++;
      if (xd[base+i] !== exp_d || xl[base+i] !== (i >= 62)) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %h/last %b required %h/last %b",
                 i, xd[base+i], xl[base+i], exp_d, (i >= 62));
      end
    end
    n_checks++;
    if (dones - d0 !== 2 || errs - e0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: got done %0d error %0d required 2 0", dones - d0, errs - e0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_empty_stall;
    test_illegal;
    test_reset_midburst;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
